// File: rtl/dcache_pkg.sv
// Shared types and constants for the direct-mapped write-back L1 data cache controller.
package dcache_pkg;
    localparam int LINES       = 32;
    localparam int LINE_BITS   = 256;
    localparam int TAG_BITS    = 22;
    localparam int INDEX_BITS  = $clog2(LINES);
    localparam int OFFSET_BITS = 5;
    localparam int ENTRY_BITS  = 24;
    localparam int VALID_BIT   = 23;
    localparam int DIRTY_BIT   = 22;

    typedef enum logic [1:0] {
        IDLE,
        WRITEBACK,
        REFILL
    } state_t;
endpackage

// File: rtl/dcache_sram.sv
// Array with async read and sync write; with CLR_FLAGS the two top bits (valid/dirty)
// are cleared asynchronously on reset while the payload bits keep their contents.
module dcache_sram #(
    parameter int WIDTH     = 24,
    parameter int DEPTH     = 32,
    parameter bit CLR_FLAGS = 1'b0
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic                     we,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata
);
    generate
        if (CLR_FLAGS) begin : g_flags
            logic [1:0]       flags [DEPTH];
            logic [WIDTH-3:0] body  [DEPTH];

            always_ff @(posedge clk_i or negedge rst_i) begin
                if (!rst_i) begin
                    for (int i = 0; i < DEPTH; i++) flags[i] <= 2'b00;
                end else if (we) begin
                    flags[addr] <= wdata[WIDTH-1 -: 2];
                end
            end

            always_ff @(posedge clk_i) begin
                if (we) body[addr] <= wdata[WIDTH-3:0];
            end

            assign rdata = {flags[addr], body[addr]};
        end else begin : g_plain
            logic [WIDTH-1:0] mem [DEPTH];
            logic             unused_rst;

            assign unused_rst = rst_i;

            always_ff @(posedge clk_i) begin
                if (we) mem[addr] <= wdata;
            end

            assign rdata = mem[addr];
        end
    endgenerate
endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back/write-allocate L1 data cache controller.
// Optional hit/miss counters are built when DCACHE_STATS_EN is defined.
module dcache_ctrl
    import dcache_pkg::*;
(
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [31:0]          p1_addr_i,
    input  logic [31:0]          p1_data_i,
    input  logic                 p1_MemRead_i,
    input  logic                 p1_MemWrite_i,
    output logic [31:0]          p1_data_o,
    output logic                 p1_stall_o,
    input  logic [LINE_BITS-1:0] mem_data_i,
    input  logic                 mem_ack_i,
    output logic [LINE_BITS-1:0] mem_data_o,
    output logic [31:0]          mem_addr_o,
    output logic                 mem_enable_o,
    output logic                 mem_write_o
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0]          hit_cnt_o,
    output logic [31:0]          miss_cnt_o
`endif
);
    state_t                  state, state_nxt;
    logic [INDEX_BITS-1:0]   idx;
    logic [TAG_BITS-1:0]     tag;
    logic [2:0]              word;
    logic [ENTRY_BITS-1:0]   tag_rd, tag_wd;
    logic                    tag_we;
    logic [LINE_BITS-1:0]    data_rd, data_wd;
    logic                    data_we;
    logic                    req, is_wr, hit, victim_dirty;
    logic                    mem_en, mem_wr;
    logic [31:0]             mem_addr;
    logic                    unused_addr_lsb;

    assign idx             = p1_addr_i[OFFSET_BITS +: INDEX_BITS];
    assign tag             = p1_addr_i[31 -: TAG_BITS];
    assign word            = p1_addr_i[4:2];
    assign unused_addr_lsb = ^p1_addr_i[1:0];
    assign req             = p1_MemRead_i | p1_MemWrite_i;
    assign is_wr           = p1_MemWrite_i;
    assign hit             = tag_rd[VALID_BIT] && (tag_rd[TAG_BITS-1:0] == tag);
    assign victim_dirty    = tag_rd[VALID_BIT] && tag_rd[DIRTY_BIT];

    dcache_sram #(.WIDTH(ENTRY_BITS), .DEPTH(LINES), .CLR_FLAGS(1'b1)) dcache_tag_sram (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .addr  (idx),
        .we    (tag_we),
        .wdata (tag_wd),
        .rdata (tag_rd)
    );

    dcache_sram #(.WIDTH(LINE_BITS), .DEPTH(LINES), .CLR_FLAGS(1'b0)) dcache_data_sram (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .addr  (idx),
        .we    (data_we),
        .wdata (data_wd),
        .rdata (data_rd)
    );

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        tag_we    = 1'b0;
        tag_wd    = tag_rd;
        data_we   = 1'b0;
        data_wd   = data_rd;
        mem_en    = 1'b0;
        mem_wr    = 1'b0;
        mem_addr  = '0;
        case (state)
            IDLE: begin
                if (req) begin
                    if (hit) begin
                        if (is_wr) begin
                            data_we                     = 1'b1;
                            data_wd[{word, 5'b0} +: 32] = p1_data_i;
                            tag_we                      = 1'b1;
                            tag_wd                      = {1'b1, 1'b1, tag};
                        end
                    end else if (victim_dirty) begin
                        state_nxt = WRITEBACK;
                    end else begin
                        state_nxt = REFILL;
                    end
                end
            end
            WRITEBACK: begin
                mem_en   = 1'b1;
                mem_wr   = 1'b1;
                mem_addr = {tag_rd[TAG_BITS-1:0], idx, 5'b0};
                if (mem_ack_i) state_nxt = REFILL;
            end
            REFILL: begin
                mem_en   = 1'b1;
                mem_addr = {p1_addr_i[31:5], 5'b0};
                if (mem_ack_i) begin
                    data_we   = 1'b1;
                    data_wd   = mem_data_i;
                    tag_we    = 1'b1;
                    tag_wd    = {1'b1, 1'b0, tag};
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs are forced quiet while reset is held, even with a request pending.
    assign p1_stall_o   = rst_i & ((req & ~hit) | (state != IDLE));
    assign p1_data_o    = rst_i ? data_rd[{word, 5'b0} +: 32] : 32'h0;
    assign mem_enable_o = rst_i & mem_en;
    assign mem_write_o  = rst_i & mem_wr;
    assign mem_addr_o   = rst_i ? mem_addr : 32'h0;
    assign mem_data_o   = (rst_i && state == WRITEBACK) ? data_rd : '0;

`ifdef DCACHE_STATS_EN
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            hit_cnt_o  <= 32'h0;
            miss_cnt_o <= 32'h0;
        end else if (state == IDLE && req) begin
            if (hit) hit_cnt_o  <= hit_cnt_o + 32'd1;
            else     miss_cnt_o <= miss_cnt_o + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_dcache_ctrl.sv
// Randomized bench for dcache_ctrl against a flat-memory / direct-mapped reference model.
module tb_dcache_ctrl;
    logic         clk_i = 1'b0;
    logic         rst_i = 1'b0;
    logic [31:0]  p1_addr_i = '0;
    logic [31:0]  p1_data_i = '0;
    logic         p1_MemRead_i = 1'b0;
    logic         p1_MemWrite_i = 1'b0;
    logic [31:0]  p1_data_o;
    logic         p1_stall_o;
    logic [255:0] mem_data_i;
    logic         mem_ack_i;
    logic [255:0] mem_data_o;
    logic [31:0]  mem_addr_o;
    logic         mem_enable_o;
    logic         mem_write_o;
`ifdef DCACHE_STATS_EN
    logic [31:0]  hit_cnt_o, miss_cnt_o;
`endif

    dcache_ctrl dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .p1_addr_i     (p1_addr_i),
        .p1_data_i     (p1_data_i),
        .p1_MemRead_i  (p1_MemRead_i),
        .p1_MemWrite_i (p1_MemWrite_i),
        .p1_data_o     (p1_data_o),
        .p1_stall_o    (p1_stall_o),
        .mem_data_i    (mem_data_i),
        .mem_ack_i     (mem_ack_i),
        .mem_data_o    (mem_data_o),
        .mem_addr_o    (mem_addr_o),
        .mem_enable_o  (mem_enable_o),
        .mem_write_o   (mem_write_o)
`ifdef DCACHE_STATS_EN
        ,
        .hit_cnt_o     (hit_cnt_o),
        .miss_cnt_o    (miss_cnt_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Backing memory (line granularity) and the CPU-visible word view.
    logic [255:0] backing [logic [26:0]];
    logic [31:0]  flat    [logic [29:0]];
    logic         ref_valid [32];
    logic         ref_dirty [32];
    logic [21:0]  ref_tag   [32];
    int           st_hits = 0, st_miss = 0;

    int           wb_cnt = 0, rf_cnt = 0, wr_cycles = 0;
    logic [31:0]  wb_addr_s = '0, rf_addr_s = '0;
    logic [255:0] wb_data_s = '0;

    function automatic logic [255:0] get_line(input logic [26:0] ln);
        logic [255:0] l;
        if (backing.exists(ln)) return backing[ln];
        for (int w = 0; w < 8; w++) l[w*32 +: 32] = 32'h5A5A_0000 ^ {ln, 5'(w)};
        return l;
    endfunction

    function automatic logic [31:0] ref_word(input logic [31:0] a);
        logic [255:0] l;
        if (flat.exists(a[31:2])) return flat[a[31:2]];
        l = get_line(a[31:5]);
        return l[{a[4:2], 5'b0} +: 32];
    endfunction

    function automatic void ref_reset();
        for (int i = 0; i < 32; i++) begin
            ref_valid[i] = 1'b0;
            ref_dirty[i] = 1'b0;
            ref_tag[i]   = '0;
        end
        flat.delete();
        st_hits = 0;
        st_miss = 0;
    endfunction

    // Memory responder: random latency, plus stray acks while idle that the DUT must ignore.
    initial begin
        int lat = 0;
        mem_ack_i  = 1'b0;
        mem_data_i = '0;
        forever begin
            @(posedge clk_i);
            #1;
            mem_ack_i = 1'b0;
            if (mem_write_o) wr_cycles++;
            if (!rst_i) begin
                lat = 0;
            end else if (mem_enable_o) begin
                if (lat == 0) lat = $urandom_range(1, 4);
                lat--;
                if (lat == 0) begin
                    if (mem_write_o) begin
                        backing[mem_addr_o[31:5]] = mem_data_o;
                        wb_cnt++;
                        wb_addr_s = mem_addr_o;
                        wb_data_s = mem_data_o;
                    end else begin
                        mem_data_i = get_line(mem_addr_o[31:5]);
                        rf_cnt++;
                        rf_addr_s = mem_addr_o;
                    end
                    mem_ack_i = 1'b1;
                end
            end else if ($urandom_range(0, 7) == 0) begin
                mem_ack_i = 1'b1;
            end
        end
    end

    task automatic idle();
        @(negedge clk_i);
        p1_MemRead_i  = 1'b0;
        p1_MemWrite_i = 1'b0;
    endtask

    task automatic access(input bit wr, input bit rd, input logic [31:0] addr, input logic [31:0] wdata);
        logic [4:0]   idx = addr[9:5];
        logic [21:0]  tg = addr[31:10];
        bit           exp_hit = ref_valid[idx] && ref_tag[idx] == tg;
        bit           exp_wb = !exp_hit && ref_valid[idx] && ref_dirty[idx];
        logic [255:0] victim = '0;
        logic [31:0]  victim_addr = {ref_tag[idx], idx, 5'b0};
        int           wb0 = wb_cnt, rf0 = rf_cnt, wc0 = wr_cycles, n = 0;
        for (int w = 0; w < 8; w++) victim[w*32 +: 32] = ref_word(victim_addr + 32'(w * 4));
        @(negedge clk_i);
        p1_addr_i     = addr;
        p1_data_i     = wdata;
        p1_MemRead_i  = rd;
        p1_MemWrite_i = wr;
        #1;
        chk("stall_first", p1_stall_o, !exp_hit);
        while (p1_stall_o && n < 200) begin
            @(negedge clk_i);
            #1;
            n++;
        end
        chk("stall_release", p1_stall_o, 1'b0);
        if (!wr) chk("load_data", p1_data_o, ref_word(addr));
        chk("wb_count", wb_cnt - wb0, exp_wb);
        chk("rf_count", rf_cnt - rf0, !exp_hit);
        if (exp_wb) begin
            chk("wb_addr", wb_addr_s, victim_addr);
            chk("wb_data", wb_data_s, victim);
        end else begin
            chk("no_mem_write", wr_cycles - wc0, 0);
        end
        if (!exp_hit) chk("rf_addr", rf_addr_s, {addr[31:5], 5'b0});
        @(posedge clk_i);
        if (wr) flat[addr[31:2]] = wdata;
        ref_dirty[idx] = (exp_hit && ref_dirty[idx]) || wr;
        ref_valid[idx] = 1'b1;
        ref_tag[idx]   = tg;
        st_hits++;
        if (!exp_hit) st_miss++;
    endtask

    task automatic reset_mid_refill();
        int n = 0;
        @(negedge clk_i);
        p1_addr_i     = 32'h0000_1040;
        p1_MemRead_i  = 1'b1;
        p1_MemWrite_i = 1'b0;
        #1;
        while (!(mem_enable_o && !mem_write_o) && n < 50) begin
            @(negedge clk_i);
            #1;
            n++;
        end
        chk("rst_refill_reached", {mem_enable_o, mem_write_o}, 2'b10);
        chk("rst_refill_addr", mem_addr_o, 32'h0000_1040);
        rst_i = 1'b0;
        #1;
        chk("rst_stall", p1_stall_o, 1'b0);
        chk("rst_enable", mem_enable_o, 1'b0);
        chk("rst_write", mem_write_o, 1'b0);
        chk("rst_addr", mem_addr_o, 32'h0);
        chk("rst_p1_data", p1_data_o, 32'h0);
        repeat (2) @(negedge clk_i);
        #1;
        chk("rst_held_stall", p1_stall_o, 1'b0);
        rst_i = 1'b1;
        ref_reset();
        p1_MemRead_i = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        ref_reset();
        backing[27'h0] = 256'h5;
        p1_MemRead_i = 1'b1;
        #3;
        chk("reset_stall", p1_stall_o, 1'b0);
        chk("reset_enable", mem_enable_o, 1'b0);
        chk("reset_write", mem_write_o, 1'b0);
        chk("reset_addr", mem_addr_o, 32'h0);
        chk("reset_mem_data", mem_data_o, 256'h0);
        chk("reset_p1_data", p1_data_o, 32'h0);
        @(negedge clk_i);
        p1_MemRead_i = 1'b0;
        rst_i = 1'b1;

        access(1'b0, 1'b1, 32'h0000_0000, 32'h0);
        chk("cold_read_word0", p1_data_o, 32'h5);
        access(1'b1, 1'b0, 32'h0000_0004, 32'hDEAD_BEEF);
        access(1'b0, 1'b1, 32'h0000_0004, 32'h0);
        chk("store_readback", p1_data_o, 32'hDEAD_BEEF);
        access(1'b0, 1'b1, 32'h0000_0400, 32'h0);
        chk("victim_low_words", wb_data_s[63:0], 64'hDEAD_BEEF_0000_0005);
        access(1'b1, 1'b0, 32'h0000_0020, 32'h1234_5678);
`ifdef DCACHE_STATS_EN
        chk("stats_miss", miss_cnt_o, 32'd3);
        chk("stats_hit", hit_cnt_o, 32'd5);
`endif
        idle();
        reset_mid_refill();
        access(1'b0, 1'b1, 32'h0000_0000, 32'h0);
        access(1'b0, 1'b1, 32'h0000_0004, 32'h0);
        chk("post_reset_wb_word", p1_data_o, 32'hDEAD_BEEF);

        for (int k = 0; k < 300; k++) begin
            logic [31:0] a;
            int          op = $urandom_range(0, 7);
            a = {22'($urandom_range(0, 3) * 32'h15), 5'($urandom_range(0, 3)),
                 3'($urandom_range(0, 7)), 2'b00};
            access(op >= 4, op <= 3 || op == 7, a, $urandom);
            repeat ($urandom_range(0, 2)) idle();
        end
`ifdef DCACHE_STATS_EN
        chk("stats_hit_final", hit_cnt_o, 32'(st_hits));
        chk("stats_miss_final", miss_cnt_o, 32'(st_miss));
`endif
        idle();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
